// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle signed multiply/divide unit that feeds the HI/LO registers
//   of the multicycle MIPS datapath. A one-cycle start in IDLE latches the
//   operands. The unit then iterates for exactly WIDTH cycles and runs one
//   fix-up cycle. Results appear on hi/lo together with a one-cycle done.
//   A divide by zero is caught when the request is accepted. It finishes
//   after one cycle, raises div_zero and leaves hi/lo untouched.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   start     request, honoured only when idle and not busy
//   op        0 = MULT, 1 = DIV (sampled with start)
//   a, b      signed operands (multiplicand/dividend, multiplier/divisor)
//   busy      high from the accepting edge until the edge after done
//   done      one-cycle completion pulse; hi/lo valid in the same cycle
//   div_zero  level flag, set by DIV with b == 0, cleared by next accept
//   hi, lo    MULT: product[2W-1:W] / product[W-1:0]
//             DIV : remainder / quotient (truncation toward zero)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DZ} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_q, op_d;
    // acc holds the Booth accumulator (MULT) or the partial remainder (DIV).
    // It is one bit wider than an operand so that no intermediate sum can
    // overflow, for example when subtracting a multiplicand of -2^(W-1).
    logic [WIDTH:0]   acc_q, acc_d;
    // work holds the multiplier, which shifts out as the product low half
    // shifts in (MULT). For DIV it holds the dividend magnitude, which
    // shifts out as the quotient bits shift in.
    logic [WIDTH-1:0] work_q, work_d;
    logic             qm1_q, qm1_d;
    // mcand holds the multiplicand (MULT) or the divisor magnitude (DIV).
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Magnitudes are taken as unsigned values, so the most negative
    // operand becomes 2^(W-1), which still fits in W bits.
    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign mcand_ext = {mcand_q[WIDTH-1], mcand_q};

    always_comb begin
        case ({work_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
        endcase
    end

    // Restoring division step: shift the next dividend bit into the
    // remainder and keep the difference only if it did not go negative.
    assign div_shift = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    assign quo_fix = neg_quo_q ? -work_q : work_q;
    assign rem_fix = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        acc_d      = acc_q;
        work_d     = work_q;
        qm1_d      = qm1_q;
        mcand_d    = mcand_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high here during the done cycle.
                // A start in that cycle is dropped, and busy falls at the
                // following edge.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    busy_d     = 1'b1;
                    op_d       = op;
                    div_zero_d = 1'b0;
                    count_d    = '0;
                    acc_d      = '0;
                    qm1_d      = 1'b0;
                    if (op) begin
                        mcand_d   = b_mag;
                        work_d    = a_mag;
                        neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_d = a[WIDTH-1];
                        state_d   = (b == '0) ? S_DZ : S_DIV;
                    end else begin
                        mcand_d = a;
                        work_d  = b;
                        state_d = S_MULT;
                    end
                end
            end
            S_MULT: begin
                // Arithmetic shift right of {acc, work, q-1} by one place.
                acc_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                work_d  = {booth_sum[0], work_q[WIDTH-1:1]};
                qm1_d   = work_q[0];
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_d  = div_diff;
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = div_shift;
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = work_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_DZ: begin
                done_d     = 1'b1;
                div_zero_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            op_q       <= 1'b0;
            acc_q      <= '0;
            work_q     <= '0;
            qm1_q      <= 1'b0;
            mcand_q    <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            work_q     <= work_d;
            qm1_q      <= qm1_d;
            mcand_q    <= mcand_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit. Directed cases plus randomized operations,
// compared against an arithmetic reference (64-bit signed multiply and
// signed divide/modulo).
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic at 64 bits, so -2^31 / -1 is exact
    // and its low word is 0x80000000. On divide by zero, hi/lo are unchanged.
    task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p      = sx * sy;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            exp_dz = 1'b0;
        end else if (y == 32'd0) begin
            exp_dz = 1'b1;
        end else begin
            q      = sx / sy;
            r      = sx % sy;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
            exp_dz = 1'b0;
        end
    endtask

    // Issue one operation. With inject set, extra DIV starts are driven
    // during the busy window and during the done cycle. The model ignores
    // them, so any effect on the result or on busy is reported.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input bit inject);
        int exp_edge;
        int got_edge;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        model(o, x, y);
        exp_edge = exp_dz ? 1 : 33;
        @(posedge clk); #1;            // edge 0 accepted the request
        start = 1'b0; a = $urandom; b = $urandom;
        check_val("busy_at_accept", 64'(busy), 64'd1);
        got_edge = 0;
        for (int n = 1; n <= 40; n++) begin
            if (inject && (n == 5 || n == 33)) begin
                start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                got_edge = n;
                break;
            end
        end
        check_val("done_edge", 64'(got_edge), 64'(exp_edge));
        check_val("hi", 64'(hi), 64'(exp_hi));
        check_val("lo", 64'(lo), 64'(exp_lo));
        check_val("div_zero", 64'(div_zero), 64'(exp_dz));
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d edge=%0d", o, x, y, hi, lo, div_zero, got_edge);
        if (inject) begin
            start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_cleared", 64'(busy), 64'd0);
        check_val("done_one_cycle", 64'(done), 64'd0);
        check_val("div_zero_hold", 64'(div_zero), 64'(exp_dz));
        if (inject) begin
            @(posedge clk); #1;
            check_val("start_in_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic        ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          done_seen;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_dz", 64'(div_zero), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check_val("mult_7x-3_hi", 64'(hi), 64'hFFFF_FFFF);
        check_val("mult_7x-3_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check_val("mult_min_hi", 64'(hi), 64'h4000_0000);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_val("div_-7/2_lo", 64'(lo), 64'hFFFF_FFFD);
        check_val("div_-7/2_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_val("div_min/-1_lo", 64'(lo), 64'h8000_0000);

        // Preload hi = 0x12345678, then divide by zero, then clear the flag.
        run_op(1'b0, 32'h48D1_59E0, 32'h4000_0000, 1'b0);
        check_val("preload_hi", 64'(hi), 64'h1234_5678);
        run_op(1'b1, 32'd5, 32'd0, 1'b0);
        check_val("dz_hi_kept", 64'(hi), 64'h1234_5678);
        run_op(1'b0, 32'd2, 32'd3, 1'b0);
        check_val("dz_cleared", 64'(div_zero), 64'd0);

        // Starts during busy and during done must be ignored.
        run_op(1'b0, 32'd3, 32'd4, 1'b1);
        check_val("ignored_start_lo", 64'(lo), 64'd12);

        for (int i = 0; i < 30; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'($urandom_range(1, 16));
                default: ry = $urandom;
            endcase
            run_op(ro, rx, ry, 1'b0);
        end

        // Reset in the middle of an operation aborts it with no done.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("midrst_hi", 64'(hi), 64'd0);
        check_val("midrst_lo", 64'(lo), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_dz", 64'(div_zero), 64'd0);
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        check_val("midrst_no_done", 64'(done_seen), 64'd0);
        $display("reset mid-operation: hi=%h lo=%h busy=%0d dones=%0d", hi, lo, busy, done_seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
